line_buffer_wr_sched: RTL and testbench



---
 rtl/line_buffer_wr_sched.sv | 126 ++++++++++++
 tb/tb_line_buffer_wr_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_wr_sched.sv
// Write-side sequencer between the IDCT output and line_buffer: steers each 4:2:0 MCU
// sample onto the Y/U/V write enable and tracks MCU/band/frame position.
module line_buffer_wr_sched #(
    parameter int COLOR_PRECISION = 8,
    parameter int ROWS_W          = 6
) (
    input  logic                       r_sysclk,
    input  logic                       r_arst,
    input  logic                       i_start,
    input  logic [8:0]                 i_hres,
    input  logic [ROWS_W-1:0]          i_mcu_rows,
    input  logic                       i_valid,
    input  logic [COLOR_PRECISION-1:0] i_data,
    output logic                       o_ready,
    input  logic                       i_full,
    output logic                       o_Y_we,
    output logic                       o_U_we,
    output logic                       o_V_we,
    output logic [COLOR_PRECISION-1:0] o_wd,
    output logic [2:0]                 o_blk,
    output logic                       o_band_done,
    output logic                       o_frame_done,
    output logic                       o_busy
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                     state;
    logic [5:0]                 smp;
    logic [2:0]                 blk;
    logic [4:0]                 mcu;
    logic [4:0]                 last_mcu;
    logic [ROWS_W-1:0]          row;
    logic [ROWS_W-1:0]          last_row;
    logic                       accept;
    logic                       smp_wrap;
    logic                       blk_wrap;
    logic                       mcu_wrap;
    logic                       row_wrap;
    logic                       y_we_p1;
    logic                       u_we_p1;
    logic                       v_we_p1;
    logic                       band_p1;
    logic                       frame_p1;
    logic [COLOR_PRECISION-1:0] wd_p1;

    localparam logic [ROWS_W-1:0] ROW_ONE = {{(ROWS_W-1){1'b0}}, 1'b1};

    // Ready must drop in the same cycle full rises, so it stays combinational.
    assign o_ready  = (state == WRITE) && !i_full;
    assign accept   = i_valid && o_ready;
    assign smp_wrap = (smp == 6'd63);
    assign blk_wrap = smp_wrap && (blk == 3'd5);
    assign mcu_wrap = blk_wrap && (mcu == last_mcu);
    assign row_wrap = mcu_wrap && (row == last_row);

    assign o_blk        = blk;
    assign o_busy       = (state != IDLE);
    assign o_Y_we       = y_we_p1;
    assign o_U_we       = u_we_p1;
    assign o_V_we       = v_we_p1;
    assign o_band_done  = band_p1;
    assign o_frame_done = frame_p1;
    assign o_wd         = wd_p1;

    always_ff @(posedge r_sysclk or posedge r_arst) begin
        if (r_arst) begin
            state    <= IDLE;
            smp      <= '0;
            blk      <= '0;
            mcu      <= '0;
            row      <= '0;
            last_mcu <= '0;
            last_row <= '0;
            y_we_p1  <= 1'b0;
            u_we_p1  <= 1'b0;
            v_we_p1  <= 1'b0;
            band_p1  <= 1'b0;
            frame_p1 <= 1'b0;
            wd_p1    <= '0;
        end else begin
            // Stage p1: one-cycle write strobe carrying the accepted sample
            y_we_p1  <= 1'b0;
            u_we_p1  <= 1'b0;
            v_we_p1  <= 1'b0;
            band_p1  <= 1'b0;
            frame_p1 <= 1'b0;
            if (accept) begin
                wd_p1    <= i_data;
                y_we_p1  <= (blk < 3'd4);
                u_we_p1  <= (blk == 3'd4);
                v_we_p1  <= (blk == 3'd5);
                band_p1  <= mcu_wrap;
                frame_p1 <= row_wrap;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= WRITE;
                        last_mcu <= i_hres[8:4];
                        last_row <= i_mcu_rows;
                        smp      <= '0;
                        blk      <= '0;
                        mcu      <= '0;
                        row      <= '0;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        smp <= smp + 6'd1;
                        if (smp_wrap)
                            blk <= (blk == 3'd5) ? 3'd0 : blk + 3'd1;
                        if (blk_wrap)
                            mcu <= (mcu == last_mcu) ? 5'd0 : mcu + 5'd1;
                        if (mcu_wrap)
                            row <= (row == last_row) ? '0 : row + ROW_ONE;
                        if (row_wrap)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_buffer_wr_sched.sv
// Randomised bench for line_buffer_wr_sched; expected writes come from a position-in-frame
// model computed from the accept count.
module tb_line_buffer_wr_sched;
    localparam int CP = 8;
    localparam int RW = 6;

    logic          r_sysclk = 1'b0;
    logic          r_arst = 1'b1;
    logic          i_start = 1'b0;
    logic [8:0]    i_hres = '0;
    logic [RW-1:0] i_mcu_rows = '0;
    logic          i_valid = 1'b0;
    logic [CP-1:0] i_data = '0;
    logic          i_full = 1'b0;
    logic          o_ready, o_Y_we, o_U_we, o_V_we, o_band_done, o_frame_done, o_busy;
    logic [CP-1:0] o_wd;
    logic [2:0]    o_blk;

    line_buffer_wr_sched #(.COLOR_PRECISION(CP), .ROWS_W(RW)) dut (
        .r_sysclk(r_sysclk), .r_arst(r_arst), .i_start(i_start), .i_hres(i_hres),
        .i_mcu_rows(i_mcu_rows), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .i_full(i_full), .o_Y_we(o_Y_we), .o_U_we(o_U_we), .o_V_we(o_V_we), .o_wd(o_wd),
        .o_blk(o_blk), .o_band_done(o_band_done), .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 r_sysclk = ~r_sysclk;

    int n_cmp = 0;
    int n_fail = 0;

    // Observations of the last step: pre-edge ready/blk, post-edge registered outputs.
    logic          rdy_s;
    logic [2:0]    blk_s;
    logic [2:0]    en_s;
    logic [CP-1:0] wd_s;
    logic          bd_s, fd_s, busy_s;

    // Model: enable by position within the 384-sample MCU (Y:0-255, U:256-319, V:320-383).
    function automatic logic [2:0] exp_en(input int k);
        int p = k % 384;
        if (p < 256) return 3'b100;
        if (p < 320) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic exp_band(input int k, input int nm);
        return ((k + 1) % (384 * nm)) == 0;
    endfunction

    function automatic logic exp_frame(input int k, input int nm, input int nr);
        return (k + 1) == 384 * nm * nr;
    endfunction

    function automatic logic [2:0] exp_blk(input int k);
        return 3'((k % 384) / 64);
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic v, input logic [CP-1:0] d, input logic f, input logic s);
        i_valid = v; i_data = d; i_full = f; i_start = s;
        #1;
        rdy_s = o_ready; blk_s = o_blk;
        @(posedge r_sysclk); #1;
        en_s = {o_Y_we, o_U_we, o_V_we}; wd_s = o_wd;
        bd_s = o_band_done; fd_s = o_frame_done; busy_s = o_busy;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge r_sysclk);
        #1;
        n_cmp++; if ({o_Y_we, o_U_we, o_V_we} !== 3'b000) begin n_fail++; $display("FAIL reset_we got=%b exp=000", {o_Y_we, o_U_we, o_V_we}); end
        n_cmp++; if (o_wd !== '0) begin n_fail++; $display("FAIL reset_wd got=%0h exp=0", o_wd); end
        n_cmp++; if (o_blk !== 3'd0) begin n_fail++; $display("FAIL reset_blk got=%0d exp=0", o_blk); end
        n_cmp++; if ({o_ready, o_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_ready_busy got=%b exp=00", {o_ready, o_busy}); end
        n_cmp++; if ({o_band_done, o_frame_done} !== 2'b00) begin n_fail++; $display("FAIL reset_done got=%b exp=00", {o_band_done, o_frame_done}); end
        r_arst = 1'b0;
    endtask

    task automatic test_full_frame();
        int k = 0, cyc = 0, ny = 0, nu = 0, nv = 0;
        logic [CP-1:0] d;
        i_hres = 9'd479; i_mcu_rows = '0;
        step(0, 0, 0, 1);
        n_cmp++; if (busy_s !== 1'b1) begin n_fail++; $display("FAIL full_busy_rise got=%b exp=1", busy_s); end
        while (k < 11520 && cyc < 12000) begin
            d = CP'($urandom);
            step(1, d, 0, 0);
            cyc++;
            if (rdy_s) begin
                n_cmp++;
                if ({en_s, wd_s, bd_s, fd_s} !== {exp_en(k), d, exp_band(k, 30), exp_frame(k, 30, 1)}) begin
                    n_fail++;
                    $display("FAIL full_write k=%0d got en=%b wd=%0h bd=%b fd=%b exp en=%b wd=%0h bd=%b fd=%b",
                             k, en_s, wd_s, bd_s, fd_s, exp_en(k), d, exp_band(k, 30), exp_frame(k, 30, 1));
                end
                ny += int'(en_s[2]); nu += int'(en_s[1]); nv += int'(en_s[0]);
                k++;
            end
        end
        n_cmp++; if (cyc !== 11520) begin n_fail++; $display("FAIL full_cycles got=%0d exp=11520", cyc); end
        n_cmp++; if (ny !== 7680) begin n_fail++; $display("FAIL full_y_count got=%0d exp=7680", ny); end
        n_cmp++; if (nu !== 1920) begin n_fail++; $display("FAIL full_u_count got=%0d exp=1920", nu); end
        n_cmp++; if (nv !== 1920) begin n_fail++; $display("FAIL full_v_count got=%0d exp=1920", nv); end
        n_cmp++; if (busy_s !== 1'b1) begin n_fail++; $display("FAIL full_busy_at_last got=%b exp=1", busy_s); end
        step(1, 0, 0, 0);
        n_cmp++;
        if ({rdy_s, en_s, busy_s} !== 5'b0) begin
            n_fail++; $display("FAIL full_done_cycle got rdy=%b en=%b busy=%b exp 0 0 0", rdy_s, en_s, busy_s);
        end
    endtask

    task automatic test_steering();
        int k = 0, cyc = 0;
        logic v;
        i_hres = 9'd15; i_mcu_rows = '0;
        step(0, 0, 0, 1);
        while (k < 384 && cyc < 2000) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, CP'(k), 0, 0);
            cyc++;
            if (v && rdy_s) begin
                n_cmp++;
                if ({blk_s, en_s, wd_s} !== {exp_blk(k), exp_en(k), CP'(k % 256)}) begin
                    n_fail++;
                    $display("FAIL steer k=%0d got blk=%0d en=%b wd=%0h exp blk=%0d en=%b wd=%0h",
                             k, blk_s, en_s, wd_s, exp_blk(k), exp_en(k), k % 256);
                end
                k++;
            end else begin
                n_cmp++;
                if (en_s !== 3'b000) begin n_fail++; $display("FAIL steer_idle_we k=%0d got=%b exp=000", k, en_s); end
            end
        end
        n_cmp++; if (k !== 384) begin n_fail++; $display("FAIL steer_timeout got=%0d exp=384", k); end
        step(0, 0, 0, 0);
    endtask

    task automatic test_stall();
        int k = 0, cyc = 0, stalls = 0;
        logic f;
        logic [CP-1:0] d;
        i_hres = 9'd15; i_mcu_rows = '0;
        step(0, 0, 0, 1);
        while (k < 384 && cyc < 1000) begin
            f = (k == 148) && (stalls < 10);
            d = CP'($urandom);
            step(1, d, f, 0);
            cyc++;
            if (f) begin
                stalls++;
                n_cmp++;
                if ({rdy_s, en_s, blk_s} !== {1'b0, 3'b000, 3'd2}) begin
                    n_fail++; $display("FAIL stall_block got rdy=%b en=%b blk=%0d exp 0 000 2", rdy_s, en_s, blk_s);
                end
            end else begin
                n_cmp++;
                if ({rdy_s, en_s, wd_s, bd_s, fd_s} !== {1'b1, exp_en(k), d, exp_band(k, 1), exp_frame(k, 1, 1)}) begin
                    n_fail++;
                    $display("FAIL stall_write k=%0d got rdy=%b en=%b wd=%0h bd=%b fd=%b exp rdy=1 en=%b wd=%0h",
                             k, rdy_s, en_s, wd_s, bd_s, fd_s, exp_en(k), d);
                end
                if (rdy_s) k++;
            end
        end
        n_cmp++; if (cyc !== 394) begin n_fail++; $display("FAIL stall_cycles got=%0d exp=394", cyc); end
        step(0, 0, 0, 0);
    endtask

    task automatic test_multi_band();
        int k = 0, cyc = 0, nb = 0, nf = 0;
        logic v;
        logic [CP-1:0] d;
        i_hres = 9'd31; i_mcu_rows = RW'(2);
        step(0, 0, 0, 1);
        while (k < 2304 && cyc < 6000) begin
            v = ($urandom_range(0, 3) != 0);
            d = CP'($urandom);
            step(v, d, 0, 0);
            cyc++;
            if (v && rdy_s) begin
                n_cmp++;
                if ({en_s, wd_s, bd_s, fd_s} !== {exp_en(k), d, exp_band(k, 2), exp_frame(k, 2, 3)}) begin
                    n_fail++;
                    $display("FAIL band_write k=%0d got en=%b bd=%b fd=%b exp en=%b bd=%b fd=%b",
                             k, en_s, bd_s, fd_s, exp_en(k), exp_band(k, 2), exp_frame(k, 2, 3));
                end
                nb += int'(bd_s); nf += int'(fd_s);
                k++;
            end
        end
        n_cmp++; if (nb !== 3) begin n_fail++; $display("FAIL band_count got=%0d exp=3", nb); end
        n_cmp++; if (nf !== 1) begin n_fail++; $display("FAIL frame_count got=%0d exp=1", nf); end
        step(0, 0, 0, 0);
    endtask

    task automatic test_start_ignored();
        int k = 0, cyc = 0;
        logic s;
        logic [CP-1:0] d;
        step(1, 8'hAA, 0, 0);
        n_cmp++;
        if ({rdy_s, en_s, busy_s} !== 5'b0) begin
            n_fail++; $display("FAIL idle_valid got rdy=%b en=%b busy=%b exp 0 000 0", rdy_s, en_s, busy_s);
        end
        i_hres = 9'd31; i_mcu_rows = '0;
        step(0, 0, 0, 1);
        while (k < 768 && cyc < 1000) begin
            s = (k == 100);
            if (s) begin i_hres = 9'd479; i_mcu_rows = RW'(5); end
            d = CP'($urandom);
            step(1, d, 0, s);
            cyc++;
            if (rdy_s) begin
                n_cmp++;
                if ({en_s, wd_s, bd_s, fd_s} !== {exp_en(k), d, exp_band(k, 2), exp_frame(k, 2, 1)}) begin
                    n_fail++;
                    $display("FAIL restart_ignored k=%0d got en=%b bd=%b fd=%b exp en=%b bd=%b fd=%b",
                             k, en_s, bd_s, fd_s, exp_en(k), exp_band(k, 2), exp_frame(k, 2, 1));
                end
                k++;
            end
        end
        step(0, 0, 0, 0);
        n_cmp++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL restart_end_busy got=%b exp=0", busy_s); end
    endtask

    task automatic test_reset_midframe();
        int k = 0, cyc = 0;
        logic [CP-1:0] d;
        i_hres = 9'd479; i_mcu_rows = '0;
        step(0, 0, 0, 1);
        while (k < 100 && cyc < 200) begin
            step(1, CP'($urandom), 0, 0);
            cyc++;
            if (rdy_s) k++;
        end
        n_cmp++; if (en_s !== 3'b100) begin n_fail++; $display("FAIL arst_pre_write got=%b exp=100", en_s); end
        r_arst = 1'b1;
        #1;
        n_cmp++;
        if ({o_Y_we, o_U_we, o_V_we, o_wd, o_blk, o_ready, o_busy, o_band_done, o_frame_done} !== '0) begin
            n_fail++;
            $display("FAIL arst_outputs got we=%b wd=%0h blk=%0d rdy=%b busy=%b exp all 0",
                     {o_Y_we, o_U_we, o_V_we}, o_wd, o_blk, o_ready, o_busy);
        end
        @(posedge r_sysclk); #1;
        r_arst = 1'b0;
        k = 0; cyc = 0;
        i_hres = 9'd15;
        step(0, 0, 0, 1);
        while (k < 384 && cyc < 500) begin
            d = CP'($urandom);
            step(1, d, 0, 0);
            cyc++;
            if (rdy_s) begin
                n_cmp++;
                if ({blk_s, en_s, wd_s, bd_s, fd_s} !== {exp_blk(k), exp_en(k), d, exp_band(k, 1), exp_frame(k, 1, 1)}) begin
                    n_fail++;
                    $display("FAIL arst_restart k=%0d got blk=%0d en=%b bd=%b fd=%b exp blk=%0d en=%b bd=%b fd=%b",
                             k, blk_s, en_s, bd_s, fd_s, exp_blk(k), exp_en(k), exp_band(k, 1), exp_frame(k, 1, 1));
                end
                k++;
            end
        end
        n_cmp++; if (k !== 384) begin n_fail++; $display("FAIL arst_restart_timeout got=%0d exp=384", k); end
        step(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        @(posedge r_sysclk); #1;
        test_full_frame();
        test_steering();
        test_stall();
        test_multi_band();
        test_start_ignored();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
